// File: rtl/x_micro_scope_reader_if.sv
// Scope-reader bus bundle: request/status, scope capture memory port and the
// downstream byte stream. master = reader, slave = scope + serializer side.
interface x_micro_scope_reader_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic              i_go;
   logic              o_start;
   logic              i_busy;
   logic              o_ren;
   logic [ADDR_W-1:0] o_raddr;
   logic [DATA_W-1:0] i_rdata;
   logic [7:0]        o_tx_data;
   logic              o_tx_valid;
   logic              i_tx_ready;
   logic              o_active;
   logic              o_done;

   modport master (
      input  i_go, i_busy, i_rdata, i_tx_ready,
      output o_start, o_ren, o_raddr, o_tx_data, o_tx_valid, o_active, o_done
   );

   modport slave (
      output i_go, i_busy, i_rdata, i_tx_ready,
      input  o_start, o_ren, o_raddr, o_tx_data, o_tx_valid, o_active, o_done
   );
endinterface

// File: rtl/x_micro_scope_reader.sv
// Arms a micro scope, waits out its capture, then drains the whole capture
// memory word by word as a little-endian byte stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for i_go
// ARM       | o_start pulse to the scope
// WAIT_RISE | wait for capture to start (busy high) or 4-cycle timeout
// WAIT_FALL | wait for capture to finish, then restart address at 0
// READ      | o_ren for the current address
// LATCH     | capture i_rdata into the shift register
// SEND      | present bytes LSB first, shift on each accepted byte
// DONE      | o_done pulse, back to IDLE
module x_micro_scope_reader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic                   i_clk,
   input  logic                   i_nrst,
   x_micro_scope_reader_if.master bus
);
   localparam int BYTES  = DATA_W / 8;
   localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [1:0]        RISE_TMO  = 2'd3;

   typedef enum logic [2:0] {
      IDLE, ARM, WAIT_RISE, WAIT_FALL, READ, LATCH, SEND, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        tmr, tmr_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [BCNT_W-1:0] bcnt, bcnt_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state <= IDLE;
         tmr   <= '0;
         addr  <= '0;
         bcnt  <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         addr  <= addr_nxt;
         bcnt  <= bcnt_nxt;
         shreg <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      addr_nxt  = addr;
      bcnt_nxt  = bcnt;
      shreg_nxt = shreg;
      case (state)
         IDLE: begin
            if (bus.i_go) state_nxt = ARM;
         end
         ARM: begin
            tmr_nxt   = RISE_TMO;
            state_nxt = WAIT_RISE;
         end
         WAIT_RISE: begin
            // busy may never be seen if the capture completes very quickly
            if (bus.i_busy || tmr == '0) state_nxt = WAIT_FALL;
            else                         tmr_nxt   = tmr - 2'd1;
         end
         WAIT_FALL: begin
            if (!bus.i_busy) begin
               addr_nxt  = '0;
               state_nxt = READ;
            end
         end
         READ: begin
            state_nxt = LATCH;
         end
         LATCH: begin
            shreg_nxt = bus.i_rdata;
            bcnt_nxt  = BCNT_LOAD;
            state_nxt = SEND;
         end
         SEND: begin
            if (bus.i_tx_ready) begin
               if (bcnt != '0) begin
                  shreg_nxt = shreg >> 8;
                  bcnt_nxt  = bcnt - 1'b1;
               end else if (addr == ADDR_LAST) begin
                  state_nxt = DONE;
               end else begin
                  addr_nxt  = addr + 1'b1;
                  state_nxt = READ;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // address only moves on the way into READ, so o_raddr holds between reads
   assign bus.o_raddr    = addr;
   assign bus.o_tx_data  = shreg[7:0];
   assign bus.o_start    = (state == ARM);
   assign bus.o_ren      = (state == READ);
   assign bus.o_tx_valid = (state == SEND);
   assign bus.o_done     = (state == DONE);
   assign bus.o_active   = (state != IDLE);
endmodule

// File: tb/tb_x_micro_scope_reader.sv
// Scoreboard bench: expected bytes are queued when a drain is requested and a
// negedge monitor pops/compares every accepted byte and read strobe.
module tb_x_micro_scope_reader;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int WORDS  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   x_micro_scope_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   x_micro_scope_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk  (clk),
      .i_nrst (nrst),
      .bus    (bus.master)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   int ecnt = 0;
   int busy_len = 0;
   bit bp_mode = 0;
   bit period_chk = 0;
   int exp_addr = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   bit ren_seen = 0;
   int first_ren_edge = 0;
   int last_ren_edge = 0;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      ecnt++;
   end

   // scope model: busy for busy_len cycles after start, 1-cycle read latency
   initial begin
      bit start_s, ren_s;
      logic [ADDR_W-1:0] a;
      int busy_cnt;
      busy_cnt = 0;
      bus.i_busy  = 1'b0;
      bus.i_rdata = '0;
      forever begin
         @(negedge clk);
         start_s = bus.o_start;
         ren_s   = bus.o_ren;
         a       = bus.o_raddr;
         @(posedge clk);
         #1;
         if (ren_s) bus.i_rdata = 32'hA0B0C000 + 32'(a);
         if (start_s) busy_cnt = busy_len;
         bus.i_busy = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt--;
      end
   end

   initial begin
      bus.i_tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.i_tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // monitor
   initial begin
      bit pv, pr, pren, pdone;
      logic [7:0] pd, e;
      pv = 0; pr = 0; pren = 0; pdone = 0; pd = '0;
      forever begin
         @(negedge clk);
         if (nrst) begin
            if (bus.o_tx_valid && bus.i_tx_ready) begin
               if (exp_q.size() == 0) chk(0, "tx_extra", bus.o_tx_data, 0);
               else begin
                  e = exp_q.pop_front();
                  chk(bus.o_tx_data == e, "tx_byte", bus.o_tx_data, e);
               end
            end
            if (pv && !pr)
               chk(bus.o_tx_valid && bus.o_tx_data == pd, "tx_hold",
                   {bus.o_tx_valid, bus.o_tx_data}, {1'b1, pd});
            if (bus.o_ren) begin
               chk(bus.o_raddr == ADDR_W'(exp_addr), "raddr", bus.o_raddr, exp_addr);
               chk(!pren, "ren_single", pren, 0);
               if (period_chk && ren_seen)
                  chk(ecnt - last_ren_edge == 6, "ren_period", ecnt - last_ren_edge, 6);
               if (!ren_seen) first_ren_edge = ecnt;
               ren_seen = 1;
               last_ren_edge = ecnt;
               exp_addr++;
            end
            if (bus.o_start) start_cnt++;
            if (bus.o_done) begin
               chk(!pdone, "done_single", pdone, 0);
               done_cnt++;
            end
         end
         pv = bus.o_tx_valid; pr = bus.i_tx_ready; pd = bus.o_tx_data;
         pren = bus.o_ren; pdone = bus.o_done;
      end
   end

   task automatic push_words(input int n);
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         w = 32'hA0B0C000 + 32'(i);
         for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      end
   endtask

   task automatic prep(input int bl, input bit bp);
      busy_len = bl;
      bp_mode = bp;
      period_chk = !bp;
      exp_addr = 0;
      start_cnt = 0;
      done_cnt = 0;
      ren_seen = 0;
   endtask

   task automatic wait_done();
      bit got;
      got = 0;
      for (int i = 0; i < 40000 && !got; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_done) got = 1;
      end
      chk(got, "done_timeout", got, 1);
   endtask

   task automatic post_drain(input int starts, input int dones);
      repeat (3) @(posedge clk);
      #1;
      chk(start_cnt == starts, "start_count", start_cnt, starts);
      chk(done_cnt == dones, "done_count", done_cnt, dones);
      chk(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
      chk(bus.o_active == 1'b0, "idle_active", bus.o_active, 0);
   endtask

   task automatic check_all_zero(input string name);
      chk({bus.o_start, bus.o_ren, bus.o_raddr, bus.o_tx_data, bus.o_tx_valid,
           bus.o_active, bus.o_done} == '0, name,
          {bus.o_start, bus.o_ren, bus.o_raddr, bus.o_tx_data, bus.o_tx_valid,
           bus.o_active, bus.o_done}, 0);
   endtask

   initial begin
      bit sent_send, hit;
      int go_edge;
      bus.i_go = 1'b0;
      #3;
      check_all_zero("reset_outputs");
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_held");
      nrst = 1'b1;
      @(posedge clk);
      #1;
      chk(bus.o_active == 1'b0, "idle_no_go", bus.o_active, 0);

      // basic drain with i_go noise during SEND and DONE
      prep(10, 0);
      push_words(WORDS);
      bus.i_go = 1'b1;
      @(posedge clk);
      #1;
      bus.i_go = 1'b0;
      chk(bus.o_start == 1'b1, "start_pulse", bus.o_start, 1);
      sent_send = 0;
      hit = 0;
      for (int i = 0; i < 40000 && !hit; i++) begin
         @(posedge clk);
         #1;
         bus.i_go = 1'b0;
         if (bus.o_done) begin
            hit = 1;
            bus.i_go = 1'b1;
         end else if (bus.o_tx_valid && !sent_send && exp_addr > 5) begin
            sent_send = 1;
            bus.i_go = 1'b1;
         end
      end
      chk(hit, "done_timeout", hit, 1);
      @(posedge clk);
      #1;
      bus.i_go = 1'b0;
      chk(bus.o_active == 1'b0, "go_in_done_ignored", bus.o_active, 0);
      post_drain(1, 1);
      chk(bus.o_raddr == ADDR_W'(WORDS - 1), "raddr_hold_last", bus.o_raddr, WORDS - 1);
      chk(exp_addr == WORDS, "read_count", exp_addr, WORDS);

      // backpressure, busy never rises
      prep(0, 1);
      push_words(WORDS);
      bus.i_go = 1'b1;
      go_edge = ecnt + 1;
      @(posedge clk);
      #1;
      bus.i_go = 1'b0;
      wait_done();
      post_drain(1, 1);
      chk(first_ren_edge - go_edge == 6, "first_ren_latency", first_ren_edge - go_edge, 6);
      chk(exp_addr == WORDS, "read_count_bp", exp_addr, WORDS);
      bp_mode = 0;

      // reset during the read of word 100, i_go held across release
      prep(10, 0);
      push_words(100);
      bus.i_go = 1'b1;
      @(posedge clk);
      #1;
      bus.i_go = 1'b0;
      hit = 0;
      for (int i = 0; i < 5000 && !hit; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_ren && bus.o_raddr == ADDR_W'(100)) hit = 1;
      end
      chk(hit, "reach_word100", hit, 1);
      #2;
      nrst = 1'b0;
      #1;
      check_all_zero("async_reset_outputs");
      bus.i_go = 1'b1;
      chk(exp_q.size() == 0, "bytes_before_reset", exp_q.size(), 0);
      chk(done_cnt == 0, "no_done_on_abort", done_cnt, 0);
      prep(10, 0);
      push_words(WORDS);
      @(posedge clk);
      #1;
      check_all_zero("reset_with_go");
      nrst = 1'b1;
      #2;
      chk(bus.o_active == 1'b0, "idle_after_release", bus.o_active, 0);
      @(posedge clk);
      #1;
      bus.i_go = 1'b0;
      chk(bus.o_start == 1'b1, "restart_arm", bus.o_start, 1);
      wait_done();
      post_drain(1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/x_micro_scope_reader.md
X_MICRO_SCOPE_READER -- requirements
Module: x_micro_scope_reader

Interface
REQ-001 Parameter ADDR_W, default 11, scope capture memory address width; depth 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, scope word width; SHALL be a multiple of 8.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_nrst  input  1  reset, asynchronous assert, active-low.
REQ-005 i_go  input  1  request: arm scope, then drain full memory; sampled only in IDLE.
REQ-006 o_start  output  1  one-cycle pulse to scope start input.
REQ-007 i_busy  input  1  scope capture-in-progress flag.
REQ-008 o_ren  output  1  scope read enable.
REQ-009 o_raddr  output  ADDR_W  scope read address.
REQ-010 i_rdata  input  DATA_W  scope read data; valid exactly 1 cycle after o_ren.
REQ-011 o_tx_data  output  8  byte stream to downstream serializer.
REQ-012 o_tx_valid  output  1  o_tx_data valid.
REQ-013 i_tx_ready  input  1  downstream accepts byte when valid and ready both high.
REQ-014 o_active  output  1  high in every state except IDLE.
REQ-015 o_done  output  1  one-cycle pulse after last byte of last word accepted.

Function
REQ-016 States SHALL be IDLE, ARM, WAIT_RISE, WAIT_FALL, READ, LATCH, SEND, DONE.
REQ-017 IDLE -> ARM when i_go high; i_go in any other state SHALL be ignored.
REQ-018 ARM: o_start high for exactly this one cycle; -> WAIT_RISE.
REQ-019 WAIT_RISE: -> WAIT_FALL when i_busy high; timeout after 4 cycles with i_busy low SHALL also go to WAIT_FALL (capture already finished).
REQ-020 WAIT_FALL: hold until i_busy low, then clear word address counter to 0 -> READ.
REQ-021 READ: o_ren high, o_raddr = address counter, for exactly one cycle -> LATCH.
REQ-022 LATCH: register i_rdata into shift register, load byte counter with DATA_W/8-1 -> SEND; o_ren low.
REQ-023 SEND: o_tx_valid high, o_tx_data = shift register bits [7:0] (LSB byte first).
REQ-024 Handshake: o_tx_valid SHALL NOT drop and o_tx_data SHALL NOT change until the byte is accepted (valid & ready).
REQ-025 On accept with byte counter nonzero: shift register right 8, decrement counter, stay SEND; next byte presented next cycle.
REQ-026 On accept of last byte: if address counter = 2**ADDR_W-1 -> DONE, else increment address -> READ.
REQ-027 Minimum per-word cost with i_tx_ready held high: 2 + DATA_W/8 cycles; bytes of one word SHALL be back-to-back.
REQ-028 Address counter SHALL NOT wrap inside a drain; final word read is 2**ADDR_W-1.
REQ-029 DONE: o_done high one cycle -> IDLE; an i_go high in the DONE cycle SHALL be ignored.
REQ-030 o_raddr SHALL hold its last value when o_ren low; o_tx_data is don't-care while o_tx_valid low, but SHALL be driven (no X).
REQ-031 i_busy rising during READ/LATCH/SEND SHALL be ignored (no re-arm, drain continues).
REQ-032 Total bytes per drain = 2**ADDR_W * DATA_W/8 (8192 at defaults).

Reset
REQ-033 i_nrst low SHALL immediately force state IDLE, counters and shift register 0, and all outputs 0 (o_raddr 0, o_tx_data 0).
REQ-034 Reset mid-drain SHALL abandon the transfer with no o_done; first cycle after release SHALL be IDLE awaiting i_go.
REQ-035 i_go high during and at release of reset SHALL be acted on only from the first clock edge with i_nrst high.

Verification
REQ-036 Basic drain: scope model with word n = 0xA0B0C000+n, busy 10 cycles, ready tied high -> o_start one pulse, 8192 bytes, first four 00,C0,B0,A0, last word 0xA0B0C7FF, o_done one pulse.
REQ-037 Backpressure: random i_tx_ready (50%) -> byte sequence identical to REQ-036, o_tx_data stable whenever valid & !ready.
REQ-038 Busy never rises: i_busy held 0 -> WAIT_RISE timeout after 4 cycles, drain proceeds, first o_ren 6 cycles after i_go.
REQ-039 Read timing: ready high -> o_ren pulses every 6 cycles, o_raddr increments 0..2047, each o_ren single-cycle.
REQ-040 Reset mid-drain at word 100 -> all outputs 0 asynchronously, no o_done; new i_go restarts from address 0.
REQ-041 i_go pulsed during SEND and during DONE -> ignored; exactly one o_start per accepted i_go.
